// File: rtl/bbc_micro_ram_arbiter.sv
// Single-port main SRAM arbiter for the BBC micro: video fetch, CPU and host
// requesters share two-cycle ISSUE/CAPTURE slots with fixed priority video > CPU > host.
module bbc_micro_ram_arbiter #(
  parameter int ADDR_WIDTH  = 16,
  parameter int VADDR_WIDTH = 15,
  parameter int DATA_WIDTH  = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable_cpu,
  input  logic                   enable_2MHz_video,
  input  logic [1:0]             phi,
  input  logic                   reset_cpu,
  input  logic                   cpu_req_valid,
  input  logic                   cpu_rnw,
  input  logic [ADDR_WIDTH-1:0]  cpu_address,
  input  logic [DATA_WIDTH-1:0]  cpu_write_data,
  output logic [DATA_WIDTH-1:0]  cpu_read_data,
  input  logic                   video_req_valid,
  input  logic [VADDR_WIDTH-1:0] video_address,
  output logic [DATA_WIDTH-1:0]  video_data,
  output logic                   video_data_valid,
  input  logic                   host_req_valid,
  output logic                   host_req_ready,
  input  logic                   host_rnw,
  input  logic [ADDR_WIDTH-1:0]  host_address,
  input  logic [DATA_WIDTH-1:0]  host_write_data,
  output logic                   host_resp_valid,
  output logic [DATA_WIDTH-1:0]  host_read_data,
  output logic                   sram_select,
  output logic                   sram_rnw,
  output logic [ADDR_WIDTH-1:0]  sram_address,
  output logic [DATA_WIDTH-1:0]  sram_write_data,
  input  logic [DATA_WIDTH-1:0]  sram_read_data,
  output logic                   cpu_overrun,
  output logic                   video_overrun
);

  typedef enum logic [2:0] {
    IDLE, VID_ISSUE, VID_CAPTURE, CPU_ISSUE, CPU_CAPTURE, HOST_ISSUE, HOST_CAPTURE
  } state_t;

  state_t                 state, state_n;
  logic                   video_pending;
  logic [VADDR_WIDTH-1:0] video_addr_q;
  logic                   cpu_done;
  logic [DATA_WIDTH-1:0]  video_q, host_q;

  logic                   video_set, video_want;
  logic                   cpu_pending, cpu_busy, cpu_want;
  logic                   pick_vid, pick_cpu, pick_host;
  logic [ADDR_WIDTH-1:0]  vid_issue_addr;

  assign video_set   = enable_2MHz_video & video_req_valid;
  assign video_want  = video_pending | video_set;
  assign cpu_pending = (phi == 2'b10) & cpu_req_valid & ~reset_cpu & ~cpu_done;
  // cpu_done only rises at the end of CPU_CAPTURE, so mask the in-flight access here
  assign cpu_busy    = (state == CPU_ISSUE) | (state == CPU_CAPTURE);
  assign cpu_want    = cpu_pending & ~cpu_busy;

  assign vid_issue_addr = ADDR_WIDTH'(video_pending ? video_addr_q : video_address);

  always_comb begin
    state_n   = state;
    pick_vid  = 1'b0;
    pick_cpu  = 1'b0;
    pick_host = 1'b0;
    case (state)
      VID_ISSUE:  state_n = VID_CAPTURE;
      CPU_ISSUE:  state_n = CPU_CAPTURE;
      HOST_ISSUE: state_n = HOST_CAPTURE;
      default: begin
        // IDLE and every CAPTURE state are arbitration points
        state_n = IDLE;
        if (video_want) begin
          pick_vid = 1'b1;
          state_n  = VID_ISSUE;
        end else if (cpu_want && !enable_cpu) begin
          pick_cpu = 1'b1;
          state_n  = CPU_ISSUE;
        end else if (host_req_valid) begin
          pick_host = 1'b1;
          state_n   = HOST_ISSUE;
        end
      end
    endcase
  end

  assign host_req_ready   = pick_host & ~reset;
  assign video_data_valid = (state == VID_CAPTURE) & ~reset;
  assign host_resp_valid  = (state == HOST_CAPTURE) & ~reset;
  // forward the SRAM byte during the capture cycle so data and its pulse coincide
  assign video_data       = video_data_valid ? sram_read_data : video_q;
  assign host_read_data   = (host_resp_valid && sram_rnw) ? sram_read_data : host_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      video_pending   <= 1'b0;
      video_addr_q    <= '0;
      cpu_done        <= 1'b0;
      cpu_overrun     <= 1'b0;
      video_overrun   <= 1'b0;
      sram_select     <= 1'b0;
      sram_rnw        <= 1'b0;
      sram_address    <= '0;
      sram_write_data <= '0;
      cpu_read_data   <= '0;
      video_q         <= '0;
      host_q          <= '0;
    end else begin
      state       <= state_n;
      sram_select <= pick_vid | pick_cpu | pick_host;

      if (pick_vid) begin
        sram_rnw     <= 1'b1;
        sram_address <= vid_issue_addr;
      end else if (pick_cpu) begin
        sram_rnw        <= cpu_rnw;
        sram_address    <= cpu_address;
        sram_write_data <= cpu_write_data;
      end else if (pick_host) begin
        sram_rnw        <= host_rnw;
        sram_address    <= host_address;
        sram_write_data <= host_write_data;
      end

      // a request arriving while one is queued displaces it into the issue slot
      if (pick_vid) video_pending <= video_pending & video_set;
      else          video_pending <= video_pending | video_set;
      if (video_set && (video_pending || !pick_vid)) video_addr_q <= video_address;

      video_overrun <= video_overrun | (video_set & video_pending);
      cpu_overrun   <= cpu_overrun | (enable_cpu & cpu_want);

      if (enable_cpu)                cpu_done <= 1'b0;
      else if (state == CPU_CAPTURE) cpu_done <= 1'b1;

      if (state == VID_CAPTURE)                 video_q       <= sram_read_data;
      if (state == CPU_CAPTURE && sram_rnw)     cpu_read_data <= sram_read_data;
      if (state == HOST_CAPTURE && sram_rnw)    host_q        <= sram_read_data;
    end
  end

endmodule

// File: tb/tb_bbc_micro_ram_arbiter.sv
// Scoreboard bench for bbc_micro_ram_arbiter: directed slot/priority/overrun cases,
// then randomized video/CPU/host traffic against a per-requester memory model.
module tb_bbc_micro_ram_arbiter;
  localparam int AW = 16, VAW = 15, DW = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic enable_cpu = 0, enable_2MHz_video = 0, reset_cpu = 0;
  logic [1:0] phi = 2'b01;
  logic cpu_req_valid = 0, cpu_rnw = 1;
  logic [AW-1:0] cpu_address = '0;
  logic [DW-1:0] cpu_write_data = '0, cpu_read_data;
  logic video_req_valid = 0;
  logic [VAW-1:0] video_address = '0;
  logic [DW-1:0] video_data;
  logic video_data_valid;
  logic host_req_valid = 0, host_req_ready, host_rnw = 1;
  logic [AW-1:0] host_address = '0;
  logic [DW-1:0] host_write_data = '0, host_read_data;
  logic host_resp_valid;
  logic sram_select, sram_rnw;
  logic [AW-1:0] sram_address;
  logic [DW-1:0] sram_write_data;
  logic [DW-1:0] sram_read_data = '0;
  logic cpu_overrun, video_overrun;

  bbc_micro_ram_arbiter #(.ADDR_WIDTH(AW), .VADDR_WIDTH(VAW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset), .enable_cpu(enable_cpu), .enable_2MHz_video(enable_2MHz_video),
    .phi(phi), .reset_cpu(reset_cpu), .cpu_req_valid(cpu_req_valid), .cpu_rnw(cpu_rnw),
    .cpu_address(cpu_address), .cpu_write_data(cpu_write_data), .cpu_read_data(cpu_read_data),
    .video_req_valid(video_req_valid), .video_address(video_address), .video_data(video_data),
    .video_data_valid(video_data_valid), .host_req_valid(host_req_valid),
    .host_req_ready(host_req_ready), .host_rnw(host_rnw), .host_address(host_address),
    .host_write_data(host_write_data), .host_resp_valid(host_resp_valid),
    .host_read_data(host_read_data), .sram_select(sram_select), .sram_rnw(sram_rnw),
    .sram_address(sram_address), .sram_write_data(sram_write_data),
    .sram_read_data(sram_read_data), .cpu_overrun(cpu_overrun), .video_overrun(video_overrun)
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] init_val(input logic [15:0] a);
    if (a == 16'hFE40) return 8'h5C;
    return a[7:0] ^ a[15:8] ^ 8'h95;
  endfunction

  // SRAM device: read data appears the cycle after a read command
  logic [7:0] mem [0:65535];
  logic mem_ready = 1'b0;
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 65536; i++) mem[i] <= init_val(16'(i));
      mem_ready <= 1'b1;
    end else if (sram_select) begin
      if (sram_rnw) sram_read_data <= mem[sram_address];
      else          mem[sram_address] <= sram_write_data;
    end
  end

  // reference model: each requester owns its own address region
  logic [7:0] ref_host [logic [15:0]];
  logic [7:0] ref_cpu  [logic [15:0]];
  logic [7:0] last_host = 8'h00, exp_cpu = 8'h00;
  logic [7:0] vq [$];
  logic [7:0] hq [$];

  function automatic logic [7:0] host_rd(input logic [15:0] a);
    return ref_host.exists(a) ? ref_host[a] : init_val(a);
  endfunction
  function automatic logic [7:0] cpu_rd(input logic [15:0] a);
    return ref_cpu.exists(a) ? ref_cpu[a] : init_val(a);
  endfunction

  always @(negedge clk) begin
    if (video_data_valid) begin
      if (vq.size() == 0) chk("video_unexpected", 1, 0);
      else chk("video_data", video_data, vq.pop_front());
    end
    if (host_resp_valid) begin
      if (hq.size() == 0) chk("host_unexpected", 1, 0);
      else chk("host_read_data", host_read_data, hq.pop_front());
    end
    if (sram_select && !sram_rnw)
      chk("write_region", (sram_address[15:8] == 8'h40) || (sram_address[15:8] == 8'h50), 1);
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic host_xfer(input logic rnw, input logic [15:0] a, input logic [7:0] wd,
                           output int waited);
    logic [7:0] e;
    host_req_valid = 1; host_rnw = rnw; host_address = a; host_write_data = wd;
    waited = 0;
    forever begin
      @(negedge clk);
      if (host_req_ready) break;
      waited++;
      if (waited > 100) begin
        chk("host_ready_timeout", 0, 1);
        host_req_valid = 0;
        return;
      end
      @(posedge clk); #1;
    end
    if (rnw) begin e = host_rd(a); last_host = e; end
    else begin ref_host[a] = wd; e = last_host; end
    hq.push_back(e);
    @(posedge clk); #1;
    host_req_valid = 0;
  endtask

  task automatic do_reset();
    reset = 1;
    tick(); tick();
    @(negedge clk);
    chk("reset_outputs", {sram_select, sram_rnw, sram_address, sram_write_data, video_data_valid,
                          host_req_ready, host_resp_valid, cpu_overrun, video_overrun}, 0);
    chk("reset_data", {video_data, host_read_data, cpu_read_data}, 0);
    last_host = 0; exp_cpu = 0;
    tick();
    reset = 0;
  endtask

  task automatic pulse_enable_cpu();
    enable_cpu = 1; tick();
    enable_cpu = 0; cpu_req_valid = 0; phi = 2'b01; tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int w, sel_cnt, wr_cnt;
  logic sel_seq [6];
  logic [15:0] adr_seq [6];
  logic auto_done = 0;

  initial begin
    // reset with a host request held: accepted at the first idle cycle
    host_req_valid = 1; host_rnw = 1; host_address = 16'h4001;
    reset = 1;
    tick(); tick();
    @(negedge clk);
    chk("reset_outputs", {sram_select, sram_rnw, sram_address, sram_write_data, video_data_valid,
                          host_req_ready, host_resp_valid, cpu_overrun, video_overrun}, 0);
    chk("reset_data", {video_data, host_read_data, cpu_read_data}, 0);
    tick();
    reset = 0;
    host_xfer(1, 16'h4001, 8'h00, w);
    chk("host_ready_after_reset", w, 0);
    repeat (4) tick();

    // single video fetch timing
    enable_2MHz_video = 1; video_req_valid = 1; video_address = 15'h3000;
    vq.push_back(init_val(16'h3000));
    tick();
    enable_2MHz_video = 0; video_req_valid = 0;
    @(negedge clk);
    chk("video_issue", {sram_select, sram_rnw, sram_address}, {2'b11, 16'h3000});
    tick();
    @(negedge clk);
    chk("video_valid_at_2", {video_data_valid, video_data}, {1'b1, 8'hA5});
    repeat (3) tick();

    // CPU read in phi2: exactly one SRAM access while the request is held
    phi = 2'b10; cpu_req_valid = 1; cpu_rnw = 1; cpu_address = 16'hFE40;
    exp_cpu = cpu_rd(16'hFE40);
    sel_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (sram_select) begin
        sel_cnt++;
        chk("cpu_read_addr", sram_address, 16'hFE40);
      end
      tick();
    end
    chk("cpu_single_access", sel_cnt, 1);
    @(negedge clk);
    chk("cpu_read_data", cpu_read_data, exp_cpu);
    pulse_enable_cpu();

    // collision: video, CPU and host all want the SRAM in one cycle
    enable_2MHz_video = 1; video_req_valid = 1; video_address = 15'h3010;
    vq.push_back(init_val(16'h3010));
    phi = 2'b10; cpu_req_valid = 1; cpu_rnw = 1; cpu_address = 16'h5010;
    exp_cpu = cpu_rd(16'h5010);
    fork
      host_xfer(1, 16'h4010, 8'h00, w);
      begin
        tick();
        enable_2MHz_video = 0; video_req_valid = 0;
        for (int i = 0; i < 6; i++) begin
          @(negedge clk);
          sel_seq[i] = sram_select; adr_seq[i] = sram_address;
          tick();
        end
      end
    join
    chk("collision_select", {sel_seq[0], sel_seq[1], sel_seq[2], sel_seq[3], sel_seq[4], sel_seq[5]},
        6'b101010);
    chk("collision_video_addr", adr_seq[0], 16'h3010);
    chk("collision_cpu_addr", adr_seq[2], 16'h5010);
    chk("collision_host_addr", adr_seq[4], 16'h4010);
    chk("collision_host_wait", w, 4);
    @(negedge clk);
    chk("collision_cpu_data", cpu_read_data, exp_cpu);
    pulse_enable_cpu();
    repeat (2) tick();

    // CPU overrun: video holds the SRAM when enable_cpu arrives
    enable_2MHz_video = 1; video_req_valid = 1; video_address = 15'h3020;
    vq.push_back(init_val(16'h3020));
    tick();
    enable_2MHz_video = 0; video_req_valid = 0;
    phi = 2'b10; cpu_req_valid = 1; cpu_rnw = 0; cpu_address = 16'h5020; cpu_write_data = 8'h77;
    wr_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (sram_select && !sram_rnw) wr_cnt++;
      tick();
      enable_cpu = (i == 0);
      if (i == 1) begin phi = 2'b01; cpu_req_valid = 0; end
    end
    enable_cpu = 0;
    chk("overrun_no_write", wr_cnt, 0);
    @(negedge clk);
    chk("cpu_overrun", {cpu_overrun, video_overrun}, 2'b10);
    tick();

    // video overrun: three back-to-back enables, the third lands while one is queued
    for (int i = 0; i < 3; i++) begin
      enable_2MHz_video = 1; video_req_valid = 1; video_address = VAW'(15'h3030 + i);
      vq.push_back(init_val(16'h3030 + 16'(i)));
      tick();
    end
    enable_2MHz_video = 0; video_req_valid = 0;
    repeat (8) tick();
    @(negedge clk);
    chk("video_overrun", video_overrun, 1);
    chk("video_queue_drained", vq.size(), 0);
    tick();
    do_reset();

    // reset_cpu masks the CPU request; host gets the slot
    phi = 2'b10; reset_cpu = 1; cpu_req_valid = 1; cpu_rnw = 1; cpu_address = 16'h5030;
    sel_cnt = 0;
    fork
      host_xfer(1, 16'h4030, 8'h00, w);
      for (int i = 0; i < 6; i++) begin
        @(negedge clk);
        if (sram_select) begin
          sel_cnt++;
          chk("reset_cpu_host_addr", sram_address, 16'h4030);
        end
        @(posedge clk); #1;
      end
    join
    chk("reset_cpu_accesses", sel_cnt, 1);
    reset_cpu = 0; cpu_req_valid = 0; phi = 2'b01;
    tick();

    // reset during a video access: no response pulse afterwards
    enable_2MHz_video = 1; video_req_valid = 1; video_address = 15'h3040;
    tick();
    enable_2MHz_video = 0; video_req_valid = 0; reset = 1;
    @(negedge clk);
    chk("abort_issue_seen", sram_select, 1);
    tick();
    @(negedge clk);
    chk("abort_no_capture", {video_data_valid, sram_select}, 0);
    tick();
    reset = 0; last_host = 0; exp_cpu = 0;
    @(negedge clk);
    chk("abort_idle", {video_data_valid, sram_select}, 0);
    tick();

    // randomized traffic under the nominal clocking pattern
    fork
      begin
        logic [7:0] r;
        for (int p = 0; p < 40; p++) begin
          for (int c = 0; c < 16; c++) begin
            phi = (c < 8) ? 2'b01 : 2'b10;
            enable_cpu = (c == 15);
            enable_2MHz_video = (c == 3) || (c == 11);
            video_req_valid = 0;
            if (enable_2MHz_video && $urandom_range(0, 3) != 0) begin
              r = 8'($urandom);
              video_req_valid = 1; video_address = VAW'({8'h30, r});
              vq.push_back(init_val({8'h30, r}));
            end
            if (c == 0) cpu_req_valid = 0;
            if (c == 8) begin
              r = 8'($urandom);
              cpu_req_valid = 1; cpu_rnw = 1'($urandom); cpu_address = {8'h50, r};
              cpu_write_data = 8'($urandom);
              if (cpu_rnw) exp_cpu = cpu_rd(cpu_address);
              else ref_cpu[cpu_address] = cpu_write_data;
            end
            if (c == 15) begin
              @(negedge clk);
              chk("rand_cpu_read_data", cpu_read_data, exp_cpu);
            end
            tick();
          end
        end
        enable_cpu = 0; enable_2MHz_video = 0; video_req_valid = 0; cpu_req_valid = 0;
        phi = 2'b01;
        auto_done = 1;
      end
      begin
        int hw;
        while (!auto_done) begin
          repeat ($urandom_range(0, 3)) tick();
          if (auto_done) break;
          host_xfer(1'($urandom), {8'h40, 8'($urandom)}, 8'($urandom), hw);
        end
      end
    join
    repeat (10) tick();
    @(negedge clk);
    chk("rand_queues_empty", {16'(vq.size()), 16'(hq.size())}, 0);
    chk("rand_no_overrun", {cpu_overrun, video_overrun}, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
